fir_mac_filter: RTL and testbench

//  Parametrised, time-multiplexed single-MAC FIR filter; successor to the fixed 128-tap/24-bit FIR.

---
 rtl/fir_pkg.sv | 53 +++++
 rtl/fir_mac.sv | 43 ++++
 rtl/fir_mac_filter.sv | 142 ++++++++++++++
 tb/tb_fir_mac_filter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
//   fir_state_e : controller states (sweep-clear, idle, multiply-accumulate, output)
//   acc_width   : accumulator width that cannot overflow for a given geometry
//   round_sat   : optional round-half-up, arithmetic shift, then clip to the output width
package fir_pkg;

  typedef enum logic [1:0] {StClear, StIdle, StMac, StDone} fir_state_e;

  // Working width for round_sat; any legal accumulator is sign-extended into it.
  localparam int unsigned MaxAccW = 128;

  typedef struct packed {
    logic                      sat;
    logic signed [MaxAccW-1:0] value;
  } sat_res_t;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic sat_res_t round_sat(input logic signed [MaxAccW-1:0] acc,
                                         input int unsigned               shift,
                                         input int unsigned               round,
                                         input int unsigned               data_w);
    logic signed [MaxAccW-1:0] one;
    logic signed [MaxAccW-1:0] t;
    logic signed [MaxAccW-1:0] hi;
    logic signed [MaxAccW-1:0] lo;
    sat_res_t                  r;
    one    = '0;
    one[0] = 1'b1;
    t      = acc;
    if (round != 0 && shift != 0) begin
      t = t + (one <<< (shift - 1));
    end
    t       = t >>> shift;
    hi      = (one <<< (data_w - 1)) - one;
    lo      = -(one <<< (data_w - 1));
    r.sat   = 1'b0;
    r.value = t;
    if (t > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (t < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply followed by accumulate.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the accumulator and drop any product in flight (start of a new sample)
//   en       : sample * coef is valid this cycle; it is registered, then accumulated a cycle later
//   acc_sum  : accumulator including the product currently in the pipeline register
module fir_mac #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned ACC_W  = 49
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc_sum
);

  localparam int unsigned ProdW = DATA_W + COEF_W;

  logic signed [ProdW-1:0] prod_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_q;

  // Exposed combinationally so the final sum can be rounded on the drain cycle.
  assign acc_sum = prod_vld_q ? acc_q + ACC_W'(prod_q) : acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_vld_q <= en;
      if (en) begin
        prod_q <= ProdW'(sample) * ProdW'(coef);
      end
      acc_q <= acc_sum;
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed single-MAC FIR filter with loadable coefficients.
//   clk, rst              : clock, synchronous active-high reset (starts a full clear sweep)
//   in_valid/in_ready     : sample handshake; in_data is the signed input sample
//   out_valid             : one-cycle pulse qualifying out_data (held) and out_sat (clipped flag)
//   coef_we/addr/data     : coefficient write, h[k] multiplies x[n-k]
//   coef_err              : one-cycle pulse after a dropped write (busy or address out of range)
module fir_mac_filter import fir_pkg::*; #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned TAPS   = 128,
  parameter int unsigned SHIFT  = 16,
  parameter int unsigned ROUND  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err
);

  localparam int unsigned    PtrW    = $clog2(TAPS);
  localparam int unsigned    AccW    = acc_width(DATA_W, COEF_W, TAPS);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(TAPS - 1);
  // TAPS modulo 2^PtrW; adding it before subtracting k gives (wr_ptr - k) mod TAPS.
  localparam logic [PtrW-1:0] TapsMod = PtrW'(TAPS);

  fir_state_e              state_q;
  logic [PtrW-1:0]         ptr_q;     // clear sweep index, then tap index k
  logic [PtrW-1:0]         wr_ptr_q;  // slot holding the newest sample
  logic                    drain_q;   // last product issued, waiting for it to accumulate
  logic [PtrW-1:0]         rd_idx;

  logic signed [DATA_W-1:0] delay_mem [TAPS];
  logic signed [COEF_W-1:0] coef_mem  [TAPS];

  logic                    accept;
  logic                    coef_ok;
  logic                    mac_en;
  logic signed [AccW-1:0]  acc_sum;
  sat_res_t                res;

  assign accept  = in_valid && in_ready && !rst;
  assign coef_ok = coef_we && in_ready && (32'(coef_addr) < TAPS) && !rst;
  assign mac_en  = (state_q == StMac) && !drain_q;
  assign rd_idx  = (wr_ptr_q >= ptr_q) ? wr_ptr_q - ptr_q : wr_ptr_q + TapsMod - ptr_q;
  assign res     = round_sat(MaxAccW'(acc_sum), SHIFT, ROUND, DATA_W);

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (AccW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .en      (mac_en),
    .sample  (delay_mem[rd_idx]),
    .coef    (coef_mem[ptr_q]),
    .acc_sum (acc_sum)
  );

  // Storage has no reset so it maps onto RAM; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      delay_mem[ptr_q] <= '0;
      coef_mem[ptr_q]  <= '0;
    end else begin
      if (accept) begin
        delay_mem[wr_ptr_q] <= in_data;
      end
      if (coef_ok) begin
        coef_mem[coef_addr] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      ptr_q     <= '0;
      wr_ptr_q  <= '0;
      drain_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      coef_err  <= coef_we && !coef_ok;
      out_valid <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (ptr_q == LastIdx) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            in_ready <= 1'b1;
          end else begin
            ptr_q <= ptr_q + PtrW'(1);
          end
        end
        StIdle, StDone: begin
          if (accept) begin
            state_q  <= StMac;
            ptr_q    <= '0;
            in_ready <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        StMac: begin
          if (!drain_q) begin
            if (ptr_q == LastIdx) begin
              drain_q <= 1'b1;
            end else begin
              ptr_q <= ptr_q + PtrW'(1);
            end
          end else begin
            // Pointer advances on entry to the output cycle so an accept there lands in the
            // next slot.
            drain_q   <= 1'b0;
            state_q   <= StDone;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= res.value[DATA_W-1:0];
            out_sat   <= res.sat;
            wr_ptr_q  <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
module tb_fir_mac_filter;

  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int CW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Config A instance
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;
  logic                 coef_we = 1'b0;
  logic [2:0]           coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 coef_err;

  fir_mac_filter #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .SHIFT(0), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
  );

  // Two small rounding instances sharing one stimulus: SHIFT=1 with ROUND=1 and ROUND=0
  logic                 s_rst = 1'b1;
  logic                 s_in_valid = 1'b0;
  logic signed [DW-1:0] s_in_data = '0;
  logic                 s_coef_we = 1'b0;
  logic [0:0]           s_coef_addr = '0;
  logic signed [CW-1:0] s_coef_data = '0;
  logic                 r1_ready, r1_valid, r1_sat, r1_err;
  logic                 r0_ready, r0_valid, r0_sat, r0_err;
  logic signed [DW-1:0] r1_data, r0_data;

  fir_mac_filter #(.DATA_W(DW), .COEF_W(CW), .TAPS(2), .SHIFT(1), .ROUND(1)) dut_r1 (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(r1_ready), .in_data(s_in_data),
    .out_valid(r1_valid), .out_data(r1_data), .out_sat(r1_sat), .coef_we(s_coef_we),
    .coef_addr(s_coef_addr), .coef_data(s_coef_data), .coef_err(r1_err)
  );

  fir_mac_filter #(.DATA_W(DW), .COEF_W(CW), .TAPS(2), .SHIFT(1), .ROUND(0)) dut_r0 (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(r0_ready), .in_data(s_in_data),
    .out_valid(r0_valid), .out_data(r0_data), .out_sat(r0_sat), .coef_we(s_coef_we),
    .coef_addr(s_coef_addr), .coef_data(s_coef_data), .coef_err(r0_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model of config A ----------------
  typedef struct {
    int     due;
    longint data;
    bit     sat;
  } exp_t;

  longint h_m [TAPS];
  longint hist[$];      // hist[0] = newest accepted sample
  exp_t   pend[$];
  int     busy    = 0;  // cycles until the filter is ready again
  bit     known   = 0;
  bit     err_pend = 0;
  bit     rst_prev = 0;

  // Observations for literal checks
  longint obs_data[$];
  bit     obs_sat[$];
  int     obs_cyc[$];

  function automatic void model_out(input longint acc, input int shift, input int round,
                                    input int dw, output longint v, output bit s);
    longint t, hi, lo;
    t  = acc + ((round != 0 && shift > 0) ? (longint'(1) << (shift - 1)) : 0);
    t  = t >>> shift;
    hi = (longint'(1) << (dw - 1)) - 1;
    lo = -(longint'(1) << (dw - 1));
    s  = 1'b1;
    if (t > hi) v = hi;
    else if (t < lo) v = lo;
    else begin
      v = t;
      s = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    bit     exp_v;
    longint acc, v;
    bit     s;
    exp_t   e;
    if (known) begin
      check("in_ready", in_ready, busy == 0);
      exp_v = pend.size() > 0 && pend[0].due == cyc;
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
        check("out_data", out_data, pend[0].data);
        check("out_sat", out_sat, pend[0].sat);
        void'(pend.pop_front());
      end
      check("coef_err", coef_err, err_pend);
      if (rst_prev) begin
        check("reset_out_data", out_data, 0);
        check("reset_out_sat", out_sat, 0);
      end
    end
    if (out_valid === 1'b1) begin
      obs_data.push_back(out_data);
      obs_sat.push_back(out_sat);
      obs_cyc.push_back(cyc);
    end
    rst_prev = rst;
    if (rst) begin
      known    = 1;
      busy     = TAPS;
      err_pend = 0;
      for (int k = 0; k < TAPS; k++) h_m[k] = 0;
      hist.delete();
      pend.delete();
    end else if (known) begin
      err_pend = coef_we && busy != 0;
      if (coef_we && busy == 0) h_m[coef_addr] = coef_data;
      if (in_valid && busy == 0) begin
        hist.push_front(in_data);
        if (hist.size() > TAPS) void'(hist.pop_back());
        acc = 0;
        for (int k = 0; k < hist.size(); k++) acc += h_m[k] * hist[k];
        model_out(acc, 0, 1, DW, v, s);
        e.due  = cyc + TAPS + 2;
        e.data = v;
        e.sat  = s;
        pend.push_back(e);
        busy = TAPS + 1;
      end else if (busy > 0) begin
        busy--;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    wait_ready("coef_wr");
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = CW'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int x);
    wait_ready("send");
    in_valid = 1'b1;
    in_data  = DW'(x);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_out();
    wait_ready("drain");
    tick();
  endtask

  task automatic s_wait(input string name, input bit want_valid);
    int n = 0;
    while (((want_valid ? r1_valid : r1_ready) !== 1'b1) && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    // 1: reset, clear sweep length
    tick();
    rst = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("clear_len", n, TAPS);
    // Coefficients were cleared: a sample gives zero
    obs_data.delete();
    send(1234);
    drain_out();
    check("zero_coef_out", (obs_data.size() > 0) ? obs_data[0] : -1, 0);

    // 2: impulse response with h[k]=k+1
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    obs_data.delete();
    obs_sat.delete();
    send(1000);
    for (int i = 0; i < TAPS; i++) send(0);
    drain_out();
    check("impulse_count", obs_data.size(), TAPS + 1);
    for (int i = 0; i <= TAPS; i++) begin
      check("impulse_val", (i < obs_data.size()) ? obs_data[i] : -1,
            (i < TAPS) ? 1000 * (i + 1) : 0);
      check("impulse_sat", (i < obs_sat.size()) ? obs_sat[i] : 1, 0);
    end

    // 3: in_valid held high, one accept per TAPS+2 cycles
    obs_cyc.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_data = DW'($urandom_range(0, 2000));
      tick();
    end
    in_valid = 1'b0;
    drain_out();
    check("stream_count_min", obs_cyc.size() >= 5, 1);
    for (int i = 1; i < obs_cyc.size(); i++)
      check("stream_period", obs_cyc[i] - obs_cyc[i-1], TAPS + 2);

    // 4: saturation both ways
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    obs_data.delete();
    obs_sat.delete();
    for (int i = 0; i < TAPS; i++) send(32767);
    drain_out();
    last = obs_data.size() - 1;
    check("sat_pos_val", (last >= 0) ? obs_data[last] : 0, 32767);
    check("sat_pos_flag", (last >= 0) ? obs_sat[last] : 0, 1);
    for (int i = 0; i < TAPS; i++) send(-32768);
    drain_out();
    last = obs_data.size() - 1;
    check("sat_neg_val", (last >= 0) ? obs_data[last] : 0, -32768);
    check("sat_neg_flag", (last >= 0) ? obs_sat[last] : 0, 1);

    // 6: write during MAC is dropped; reset mid-MAC leaves no residue
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    send(500);
    tick();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd99;
    tick();
    coef_we = 1'b0;
    check("busy_write_err", coef_err, 1);
    obs_data.delete();
    drain_out();
    check("busy_write_ignored", (obs_data.size() > 0) ? obs_data[0] : -1, 500);
    send(700);
    tick();
    tick();
    tick();
    obs_data.delete();
    do_reset();
    wait_ready("post_rst");
    check("rst_no_out", obs_data.size(), 0);
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    send(1000);
    drain_out();
    check("clean_after_rst", (obs_data.size() > 0) ? obs_data[0] : -1, 1000);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = DW'($urandom);
      coef_we   = ($urandom_range(0, 9) == 0);
      coef_addr = 3'($urandom);
      coef_data = CW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 400));
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    repeat (20) tick();

    // 5: rounding
    s_rst = 1'b0;
    s_wait("s_ready", 0);
    s_coef_we   = 1'b1;
    s_coef_addr = 1'b0;
    s_coef_data = 16'sd1;
    tick();
    s_coef_we  = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = 16'sd3;
    tick();
    s_in_valid = 1'b0;
    s_wait("s_out1", 1);
    check("round_pos", r1_data, 2);
    check("trunc_pos", r0_data, 1);
    check("round_pos_valid_r0", r0_valid, 1);
    check("round_pos_sat", r1_sat, 0);
    s_in_valid = 1'b1;
    s_in_data  = -16'sd3;
    tick();
    s_in_valid = 1'b0;
    s_wait("s_out2", 1);
    check("round_neg", r1_data, -1);
    check("trunc_neg", r0_data, -2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
